bullet_pool: RTL and testbench

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pkg.sv | 18 +
 rtl/bullet_slot.sv | 83 ++++++++
 rtl/bullet_pool.sv | 101 ++++++++++
 tb/tb_bullet_pool.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared screen geometry, slot state and direction encodings for the bullet pool.
package bullet_pkg;

    localparam int SCREEN_H = 480;
    localparam int BULLET_W = 2;
    localparam int BULLET_H = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_t;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: IDLE/ACTIVE state, per-frame vertical motion, hit kill and pixel hit-test.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int SPEED   = 4,
    parameter int SPAWN_Y = 440
) (
    input  logic       clk_60hz,
    input  logic       reset_n,
    input  logic       alloc,
    input  logic [9:0] alloc_x,
    input  dir_t       alloc_dir,
    input  logic       hit,
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       in_use,
    output logic       pixel
);

    localparam logic [10:0] SPEED_EXT = 11'(SPEED);
    localparam logic [10:0] Y_LIMIT   = 11'(SCREEN_H - BULLET_H);
    localparam logic [10:0] W_EXT     = 11'(BULLET_W);
    localparam logic [10:0] H_EXT     = 11'(BULLET_H);
    localparam logic [9:0]  SPAWN_V   = 10'(SPAWN_Y);

    slot_state_t state;
    logic [9:0]  x;
    logic [9:0]  y;
    dir_t        dir;

    logic [10:0] y_ext;
    logic [10:0] y_up;
    logic [10:0] y_down;
    logic        off_top;
    logic        off_bottom;
    logic        leave;

    // Motion is evaluated at 11 bits so neither edge of the screen can wrap.
    assign y_ext      = {1'b0, y};
    assign y_up       = y_ext - SPEED_EXT;
    assign y_down     = y_ext + SPEED_EXT;
    assign off_top    = (y_ext < SPEED_EXT);
    assign off_bottom = (y_down > Y_LIMIT);
    assign leave      = (dir == UP) ? off_top : off_bottom;

    always_ff @(posedge clk_60hz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            dir   <= DOWN;
        end else if (state == ACTIVE) begin
            if (hit || leave) begin
                state <= IDLE;
            end else if (dir == UP) begin
                y <= y_up[9:0];
            end else begin
                y <= y_down[9:0];
            end
        end else if (alloc) begin
            state <= ACTIVE;
            x     <= alloc_x;
            y     <= SPAWN_V;
            dir   <= alloc_dir;
        end
    end

    logic [10:0] px_ext;
    logic [10:0] py_ext;
    logic [10:0] x_ext;
    logic        in_x;
    logic        in_y;

    assign px_ext = {1'b0, px};
    assign py_ext = {1'b0, py};
    assign x_ext  = {1'b0, x};
    assign in_x   = (px_ext >= x_ext) && (px_ext < x_ext + W_EXT);
    assign in_y   = (py_ext >= y_ext) && (py_ext < y_ext + H_EXT);

    assign in_use = (state == ACTIVE);
    assign pixel  = in_use && in_x && in_y;

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: fire edge detection, cooldown, lowest-free-slot allocation over NUM_BULLETS slots.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 4,
    parameter int COOLDOWN    = 8,
    parameter int SPAWN_Y     = 440
) (
    input  logic                   clk_60hz,
    input  logic                   reset_n,
    input  logic [9:0]             px,
    input  logic [9:0]             py,
    input  logic [9:0]             ship_x,
    input  logic                   shoot_up,
    input  logic                   shoot_down,
    input  logic [NUM_BULLETS-1:0] hit,
    output logic [NUM_BULLETS-1:0] pixel,
    output logic [NUM_BULLETS-1:0] in_use,
    output logic                   fire_ack,
    output logic                   fire_drop
);

    localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN);
    // Reload one short so the next accept can land exactly COOLDOWN frames after this one.
    localparam logic [CD_W-1:0] CD_RELOAD = CD_W'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);

    function automatic logic [CD_W-1:0] sat_dec(input logic [CD_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    logic            shoot_up_p1;
    logic            shoot_down_p1;
    logic            armed_p1;
    logic [CD_W-1:0] cooldown;

    logic up_edge;
    logic down_edge;
    logic fire_req;
    logic accept;
    dir_t fire_dir;

    // No edge is seen on the first frame after reset, so a level held through reset never fires.
    assign up_edge   = armed_p1 && shoot_up && !shoot_up_p1;
    assign down_edge = armed_p1 && shoot_down && !shoot_down_p1;
    assign fire_req  = up_edge || down_edge;
    assign fire_dir  = up_edge ? UP : DOWN;

    logic [NUM_BULLETS-1:0] alloc_vec;
    logic                   found;

    always_comb begin
        alloc_vec = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!in_use[i] && !found) begin
                alloc_vec[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign accept = fire_req && (cooldown == '0) && found;

    always_ff @(posedge clk_60hz or negedge reset_n) begin
        if (!reset_n) begin
            shoot_up_p1   <= 1'b0;
            shoot_down_p1 <= 1'b0;
            armed_p1      <= 1'b0;
            cooldown      <= '0;
            fire_ack      <= 1'b0;
            fire_drop     <= 1'b0;
        end else begin
            shoot_up_p1   <= shoot_up;
            shoot_down_p1 <= shoot_down;
            armed_p1      <= 1'b1;
            cooldown      <= accept ? CD_RELOAD : sat_dec(cooldown);
            fire_ack      <= accept;
            fire_drop     <= fire_req && !accept;
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .SPEED   (SPEED),
            .SPAWN_Y (SPAWN_Y)
        ) u_slot (
            .clk_60hz  (clk_60hz),
            .reset_n   (reset_n),
            .alloc     (accept && alloc_vec[g]),
            .alloc_x   (ship_x),
            .alloc_dir (fire_dir),
            .hit       (hit[g]),
            .px        (px),
            .py        (py),
            .in_use    (in_use[g]),
            .pixel     (pixel[g])
        );
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: default instance plus a no-cooldown, SPAWN_Y=443 instance.
module tb_bullet_pool;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] px, py, ship_x;
    logic       su, sd, su0, sd0;
    logic [3:0] hit;

    logic [3:0] pixel, in_use, pixel0, in_use0;
    logic       ack, drop, ack0, drop0;

    int n_checks = 0;
    int n_fail   = 0;

    string      sb_tag[$];
    logic [5:0] sb_exp[$];

    always #5 clk = ~clk;

    bullet_pool dut (
        .clk_60hz(clk), .reset_n(reset_n), .px(px), .py(py), .ship_x(ship_x),
        .shoot_up(su), .shoot_down(sd), .hit(hit),
        .pixel(pixel), .in_use(in_use), .fire_ack(ack), .fire_drop(drop)
    );

    bullet_pool #(.NUM_BULLETS(4), .SPEED(4), .COOLDOWN(0), .SPAWN_Y(443)) dut0 (
        .clk_60hz(clk), .reset_n(reset_n), .px(px), .py(py), .ship_x(ship_x),
        .shoot_up(su0), .shoot_down(sd0), .hit(hit),
        .pixel(pixel0), .in_use(in_use0), .fire_ack(ack0), .fire_drop(drop0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp = {fire_ack, fire_drop, in_use} after the edge
    task automatic step(input string tag, input bit sel, input logic u, input logic d,
                        input logic [3:0] hv, input logic [5:0] exp);
        logic [5:0] got;
        if (sel) begin su0 = u; sd0 = d; end
        else     begin su  = u; sd  = d; end
        hit = hv;
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
        @(posedge clk);
        #1;
        got = sel ? {ack0, drop0, in_use0} : {ack, drop, in_use};
        check(sb_tag.pop_front(), got, sb_exp.pop_front());
    endtask

    task automatic idle(input string tag, input bit sel, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) step(tag, sel, 1'b0, 1'b0, 4'b0000, exp);
    endtask

    task automatic probe(input string tag, input bit sel, input logic [9:0] x,
                         input logic [9:0] y, input logic [3:0] exp);
        px = x;
        py = y;
        #1;
        check(tag, sel ? pixel0 : pixel, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        su = 1'b1; sd = 1'b0; su0 = 1'b0; sd0 = 1'b0;
        hit = '0; px = '0; py = '0; ship_x = 10'd100;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_use", in_use, 4'b0000);
        check("rst_ack_drop", {ack, drop}, 2'b00);
        probe("rst_pixel", 1'b0, 10'd0, 10'd0, 4'b0000);
        reset_n = 1'b1;

        // shoot_up held through reset release must not fire
        step("held_r1", 0, 1, 0, 4'b0000, 6'b00_0000);
        step("held_r2", 0, 1, 0, 4'b0000, 6'b00_0000);
        step("held_r3", 0, 0, 0, 4'b0000, 6'b00_0000);

        step("fire_e0", 0, 1, 0, 4'b0000, 6'b10_0001);
        probe("spawn_pix", 0, 10'd100, 10'd440, 4'b0001);
        step("move_e1", 0, 0, 0, 4'b0000, 6'b00_0001);
        probe("pix_in", 0, 10'd101, 10'd437, 4'b0001);
        probe("pix_right", 0, 10'd102, 10'd437, 4'b0000);
        probe("pix_above", 0, 10'd100, 10'd435, 4'b0000);
        step("e2", 0, 0, 0, 4'b0000, 6'b00_0001);
        step("cd_drop_e3", 0, 1, 0, 4'b0000, 6'b01_0001);
        idle("e4_7", 0, 4, 6'b00_0001);
        step("cd_ack_e8", 0, 1, 0, 4'b0000, 6'b10_0011);
        idle("e9_15", 0, 7, 6'b00_0011);

        step("hit_fire_e16", 0, 1, 0, 4'b0010, 6'b10_0101);
        step("hit_idle_e17", 0, 0, 0, 4'b1000, 6'b00_0101);
        idle("e18_23", 0, 6, 6'b00_0101);

        ship_x = 10'd200;
        step("both_e24", 0, 1, 1, 4'b0000, 6'b10_0111);
        step("e25", 0, 0, 0, 4'b0000, 6'b00_0111);
        probe("dir_up_pix", 0, 10'd200, 10'd436, 4'b0010);
        probe("dir_not_down", 0, 10'd200, 10'd444, 4'b0000);
        idle("e26_31", 0, 6, 6'b00_0111);

        ship_x = 10'd300;
        step("down_e32", 0, 0, 1, 4'b0000, 6'b10_1111);
        idle("e33_39", 0, 7, 6'b00_1111);
        step("full_drop_e40", 0, 1, 0, 4'b0000, 6'b01_1111);
        probe("y472_pix", 0, 10'd300, 10'd472, 4'b1000);
        probe("y472_bot", 0, 10'd301, 10'd477, 4'b1000);
        probe("y472_past", 0, 10'd300, 10'd478, 4'b0000);
        step("freed_drop_e41", 0, 0, 1, 4'b0000, 6'b01_0111);
        step("e42", 0, 0, 0, 4'b0000, 6'b00_0111);
        step("realloc_e43", 0, 1, 0, 4'b0000, 6'b10_1111);
        step("e44", 0, 0, 0, 4'b0000, 6'b00_1111);
        probe("flight_pix", 0, 10'd200, 10'd360, 4'b0010);

        reset_n = 1'b0;
        #1;
        check("midrst_in_use", in_use, 4'b0000);
        check("midrst_pixel", pixel, 4'b0000);
        check("midrst_ack_drop", {ack, drop}, 2'b00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("post_rst", 0, 0, 0, 4'b0000, 6'b00_0000);

        // second instance: no cooldown, spawn at 443
        ship_x = 10'd50;
        step("nc_f0", 1, 1, 0, 4'b0000, 6'b10_0001);
        step("nc_f1", 1, 0, 1, 4'b0000, 6'b10_0011);
        step("nc_f2", 1, 1, 0, 4'b0000, 6'b10_0111);
        step("nc_f3", 1, 0, 1, 4'b0000, 6'b10_1111);
        step("nc_f4_drop", 1, 1, 0, 4'b0000, 6'b01_1111);
        step("nc_f5", 1, 0, 0, 4'b0000, 6'b00_1111);
        idle("nc_f6_8", 1, 3, 6'b00_1111);
        step("nc_f9_down_exit", 1, 0, 0, 4'b0000, 6'b00_1101);
        step("nc_f10", 1, 0, 0, 4'b0000, 6'b00_1101);
        step("nc_f11_down_exit", 1, 0, 0, 4'b0000, 6'b00_0101);
        idle("nc_f12_110", 1, 99, 6'b00_0101);
        probe("nc_y3_pix", 1, 10'd50, 10'd3, 4'b0001);
        probe("nc_y3_above", 1, 10'd50, 10'd2, 4'b0000);
        step("nc_f111_up_exit", 1, 0, 0, 4'b0000, 6'b00_0100);
        probe("nc_no_wrap", 1, 10'd50, 10'd1023, 4'b0000);
        probe("nc_gone_y3", 1, 10'd50, 10'd3, 4'b0000);
        step("nc_f112", 1, 0, 0, 4'b0000, 6'b00_0100);
        step("nc_f113", 1, 0, 0, 4'b0000, 6'b00_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
